// File: rtl/mac_symbol_packer.sv
// rtl/mac_symbol_packer.sv - packs a requested serial bit stream into LSB-first symbols behind a FWFT FIFO
// Optional build macro: MAC_PACKER_GRAY_EN (Gray-map each packed symbol before it is queued).
module mac_symbol_packer #(
  parameter int DEPTH   = 4,
  parameter int SYM_W   = 4,
  parameter int FRAME_W = 10
) (
  input  logic               SERIAL_CLK,
  input  logic               MAC_RST_N,
  input  logic               START,
  input  logic [2:0]         BITS_PER_SYM,
  input  logic [FRAME_W-1:0] SYMS_PER_FRAME,
  output logic               FRAME_RST,
  output logic               READ_ENABLE,
  input  logic               BIT_IN,
  input  logic               BIT_IN_VALID,
  output logic [SYM_W-1:0]   SYM_OUT,
  output logic               SYM_VALID,
  input  logic               SYM_READY,
  output logic               SYM_LAST,
  output logic               BUSY,
  output logic               FRAME_DONE
);

  localparam int TOT_W = FRAME_W + 3;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         bps_q, bps_d;
  logic [FRAME_W-1:0] spf_q, spf_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [TOT_W-1:0]   req_q, req_d;
  logic [TOT_W-1:0]   rx_q, rx_d;
  logic [SYM_W-1:0]   acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] sym_q, sym_d;
  logic [1:0]         re_hist_q, re_hist_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_rst_q, frame_rst_d;
  logic               frame_done_q, frame_done_d;
  logic [SYM_W:0]     mem_q [DEPTH];

  logic               start_ok, fifo_empty, pop, push, bit_ok, re;
  logic [SYM_W:0]     head, push_data;
  logic [SYM_W-1:0]   acc_new, packed_v;

  always_comb begin
    start_ok   = START && (SYMS_PER_FRAME != '0) && (BITS_PER_SYM != 3'd0)
                 && (int'(BITS_PER_SYM) <= SYM_W);
    fifo_empty = (cnt_q == '0);
    head       = mem_q[rd_q];
    pop        = !fifo_empty && SYM_READY;
    // Bits already requested but not yet returned count against free space.
    re         = MAC_RST_N && (state_q == S_RUN) && (req_q < total_q)
                 && ((int'(cnt_q) + int'(re_hist_q[0]) + int'(re_hist_q[1])) < DEPTH);
    bit_ok     = BIT_IN_VALID && ((state_q == S_RUN) || (state_q == S_DRAIN))
                 && (rx_q < total_q);
    acc_new    = acc_q | (SYM_W'(BIT_IN) << idx_q);
    push       = bit_ok && (idx_q == (bps_q - 3'd1));
`ifdef MAC_PACKER_GRAY_EN
    packed_v   = acc_new ^ (acc_new >> 1);
`else
    packed_v   = acc_new;
`endif
    push_data  = {(sym_q == (spf_q - FRAME_W'(1))), packed_v};
  end

  always_comb begin
    state_d      = state_q;
    bps_d        = bps_q;
    spf_d        = spf_q;
    total_d      = total_q;
    req_d        = req_q;
    rx_d         = rx_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    sym_d        = sym_q;
    re_hist_d    = {re_hist_q[0], re};
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_PRIME;
          bps_d   = BITS_PER_SYM;
          spf_d   = SYMS_PER_FRAME;
          total_d = TOT_W'(SYMS_PER_FRAME) * TOT_W'(BITS_PER_SYM);
          req_d   = '0;
          rx_d    = '0;
          acc_d   = '0;
          idx_d   = '0;
          sym_d   = '0;
        end
      end
      S_PRIME: state_d = S_RUN;
      S_RUN:   if (req_q == total_q) state_d = S_DRAIN;
      default: ;
    endcase

    if (re) req_d = req_q + TOT_W'(1);

    if (bit_ok) begin
      rx_d = rx_q + TOT_W'(1);
      if (push) begin
        acc_d = '0;
        idx_d = '0;
        sym_d = sym_q + FRAME_W'(1);
      end else begin
        acc_d = acc_new;
        idx_d = idx_q + 3'd1;
      end
    end

    if (push) wr_d = wr_q + PTR_W'(1);
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
      if (head[SYM_W]) begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
    end

    frame_rst_d = (state_d == S_PRIME);
  end

  always_ff @(posedge SERIAL_CLK) begin
    if (!MAC_RST_N) begin
      state_q      <= S_IDLE;
      bps_q        <= '0;
      spf_q        <= '0;
      total_q      <= '0;
      req_q        <= '0;
      rx_q         <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      sym_q        <= '0;
      re_hist_q    <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      frame_rst_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bps_q        <= bps_d;
      spf_q        <= spf_d;
      total_q      <= total_d;
      req_q        <= req_d;
      rx_q         <= rx_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sym_q        <= sym_d;
      re_hist_q    <= re_hist_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      frame_rst_q  <= frame_rst_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks whatever the entries hold.
  always_ff @(posedge SERIAL_CLK) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign FRAME_RST   = frame_rst_q;
  assign READ_ENABLE = re;
  assign SYM_VALID   = !fifo_empty;
  assign SYM_OUT     = fifo_empty ? '0 : head[SYM_W-1:0];
  assign SYM_LAST    = !fifo_empty && head[SYM_W];
  assign BUSY        = (state_q != S_IDLE);
  assign FRAME_DONE  = frame_done_q;

endmodule

// File: tb/tb_mac_symbol_packer.sv
// tb/tb_mac_symbol_packer.sv - directed scoreboard bench for mac_symbol_packer with a 2-cycle upstream model
module tb_mac_symbol_packer;

  logic       SERIAL_CLK = 1'b0;
  logic       MAC_RST_N, START, FRAME_RST, READ_ENABLE, BIT_IN, BIT_IN_VALID;
  logic [2:0] BITS_PER_SYM;
  logic [9:0] SYMS_PER_FRAME;
  logic [3:0] SYM_OUT;
  logic       SYM_VALID, SYM_READY, SYM_LAST, BUSY, FRAME_DONE;

  mac_symbol_packer #(.DEPTH(4), .SYM_W(4), .FRAME_W(10)) dut (
    .SERIAL_CLK(SERIAL_CLK), .MAC_RST_N(MAC_RST_N), .START(START),
    .BITS_PER_SYM(BITS_PER_SYM), .SYMS_PER_FRAME(SYMS_PER_FRAME),
    .FRAME_RST(FRAME_RST), .READ_ENABLE(READ_ENABLE), .BIT_IN(BIT_IN),
    .BIT_IN_VALID(BIT_IN_VALID), .SYM_OUT(SYM_OUT), .SYM_VALID(SYM_VALID),
    .SYM_READY(SYM_READY), .SYM_LAST(SYM_LAST), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 SERIAL_CLK = ~SERIAL_CLK;

  typedef struct packed {logic last; logic [3:0] val;} exp_t;

  exp_t       exp_q[$];
  logic       pat_q[$];
  int         errors = 0, checks = 0;
  int         re_cnt = 0, frst_cnt = 0, done_cnt = 0, pops = 0, cap_n = 0;
  logic [4:0] cap [32];
  logic [4:0] ref_syms [5];
  logic       ref_bits [15];
  logic [3:0] last_sym;
  logic       h1 = 1'b0, h2 = 1'b0;
  logic       m_active = 1'b0;
  int         m_bps, m_spf, m_rcvd, m_idx, m_sym;
  logic [3:0] m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic next_bit();
    if (pat_q.size() != 0) return pat_q.pop_front();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_bit(input logic b);
    logic [3:0] v;
    exp_t e;
    if (m_active && m_rcvd < m_bps * m_spf) begin
      m_acc[m_idx] = b;
      m_rcvd++;
      m_idx++;
      if (m_idx == m_bps) begin
        v = m_acc;
`ifdef MAC_PACKER_GRAY_EN
        v = v ^ (v >> 1);
`endif
        e.last = (m_sym == m_spf - 1);
        e.val  = v;
        exp_q.push_back(e);
        m_sym++;
        m_idx = 0;
        m_acc = '0;
      end
    end
  endtask

  task automatic tick();
    logic       hold_pre, done_now;
    logic [4:0] sym_pre;
    exp_t       e;
    hold_pre = MAC_RST_N && SYM_VALID && !SYM_READY;
    sym_pre  = {SYM_LAST, SYM_OUT};
    done_now = 1'b0;
    if (MAC_RST_N && SYM_VALID && SYM_READY) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(sym_pre), 32'h1f);
      end else begin
        e = exp_q.pop_front();
        chk("sym_data", 32'(SYM_OUT), 32'(e.val));
        chk("sym_last", 32'(SYM_LAST), 32'(e.last));
        last_sym = SYM_OUT;
        pops++;
        if (cap_n < 32) cap[cap_n] = sym_pre;
        cap_n++;
        if (e.last) begin
          done_now = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    @(negedge SERIAL_CLK);
    if (hold_pre) chk("hold_stable", 32'({SYM_LAST, SYM_OUT}), 32'(sym_pre));
    chk("frame_done", 32'(FRAME_DONE), 32'(done_now));
    if (READ_ENABLE) re_cnt++;
    if (FRAME_RST)   frst_cnt++;
    if (FRAME_DONE)  done_cnt++;
    BIT_IN_VALID = h2;
    BIT_IN       = h2 ? next_bit() : 1'b0;
    if (h2) model_bit(BIT_IN);
    h2 = h1;
    h1 = READ_ENABLE;
  endtask

  task automatic start_frame(input int bps, input int spf);
    BITS_PER_SYM   = 3'(bps);
    SYMS_PER_FRAME = 10'(spf);
    START          = 1'b1;
    if (!m_active && spf != 0 && bps >= 1 && bps <= 4) begin
      m_active = 1'b1;
      m_bps = bps; m_spf = spf;
      m_rcvd = 0; m_idx = 0; m_sym = 0; m_acc = '0;
    end
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < maxc) begin tick(); n++; end
    chk("done_timeout", 32'(done_cnt != d0), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({FRAME_RST, READ_ENABLE, SYM_OUT, SYM_VALID, SYM_LAST, BUSY, FRAME_DONE});
  endfunction

  initial begin
    int re0, fr0, p0, d0, n;
    int bad_bps [3] = '{2, 0, 5};
    int bad_spf [3] = '{0, 3, 3};
    MAC_RST_N = 1'b0; START = 1'b0; BITS_PER_SYM = '0; SYMS_PER_FRAME = '0;
    BIT_IN = 1'b0; BIT_IN_VALID = 1'b0; SYM_READY = 1'b0;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 32'd0);
    MAC_RST_N = 1'b1;
    tick();
    chk("idle_outs", all_outs(), 32'd0);

    // Basic frame: BPS=2, SPF=3, always ready.
    SYM_READY = 1'b1;
    re0 = re_cnt; fr0 = frst_cnt; p0 = pops; d0 = done_cnt;
    start_frame(2, 3);
    chk("prime_frame_rst", 32'(FRAME_RST), 32'd1);
    chk("prime_re_low", 32'(READ_ENABLE), 32'd0);
    chk("prime_busy", 32'(BUSY), 32'd1);
    wait_done(200);
    tick();
    chk("f1_frame_rst_cnt", 32'(frst_cnt - fr0), 32'd1);
    chk("f1_re_cnt", 32'(re_cnt - re0), 32'd6);
    chk("f1_pops", 32'(pops - p0), 32'd3);
    chk("f1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("f1_busy_after", 32'(BUSY), 32'd0);

    // Fixed bit pattern 1,0,1,1 with BPS=4.
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    start_frame(4, 1);
    wait_done(200);
`ifdef MAC_PACKER_GRAY_EN
    chk("pattern_sym", 32'(last_sym), 32'hB);
`else
    chk("pattern_sym", 32'(last_sym), 32'hD);
`endif

    // Backpressure: BPS=1, SPF=16, downstream stalled.
    SYM_READY = 1'b0;
    re0 = re_cnt; p0 = pops;
    start_frame(1, 16);
    repeat (30) tick();
    chk("stall_re_cnt", 32'(re_cnt - re0), 32'd4);
    chk("stall_re_low", 32'(READ_ENABLE), 32'd0);
    chk("stall_valid", 32'(SYM_VALID), 32'd1);
    chk("stall_queued", 32'(exp_q.size()), 32'd4);
    SYM_READY = 1'b1;
    wait_done(400);
    chk("stall_pops", 32'(pops - p0), 32'd16);

    // Illegal START requests are ignored.
    for (int i = 0; i < 3; i++) begin
      fr0 = frst_cnt;
      start_frame(bad_bps[i], bad_spf[i]);
      repeat (3) tick();
      chk("illegal_busy", 32'(BUSY), 32'd0);
      chk("illegal_frame_rst", 32'(frst_cnt - fr0), 32'd0);
    end

    // Reference frame, then the same frame interrupted by reset, then repeated.
    for (int i = 0; i < 15; i++) ref_bits[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 15; i++) pat_q.push_back(ref_bits[i]);
    cap_n = 0;
    start_frame(3, 5);
    wait_done(300);
    for (int i = 0; i < 5; i++) ref_syms[i] = cap[i];
    repeat (2) tick();
    cap_n = 0;
    start_frame(3, 5);
    n = 0;
    while (cap_n < 2 && n < 200) begin tick(); n++; end
    chk("pre_reset_pops", 32'(cap_n >= 2), 32'd1);
    MAC_RST_N = 1'b0;
    m_active = 1'b0;
    exp_q.delete();
    tick();
    chk("midrun_reset_outs", all_outs(), 32'd0);
    MAC_RST_N = 1'b1;
    repeat (4) tick();
    chk("post_reset_outs", all_outs(), 32'd0);
    pat_q.delete();
    for (int i = 0; i < 15; i++) pat_q.push_back(ref_bits[i]);
    cap_n = 0;
    start_frame(3, 5);
    wait_done(300);
    for (int i = 0; i < 5; i++) chk("rerun_matches_ref", 32'(cap[i]), 32'(ref_syms[i]));

    // START during RUN must not disturb the frame.
    repeat (2) tick();
    p0 = pops; fr0 = frst_cnt;
    start_frame(2, 4);
    repeat (5) tick();
    chk("run_busy", 32'(BUSY), 32'd1);
    start_frame(1, 7);
    wait_done(300);
    chk("rerun_start_pops", 32'(pops - p0), 32'd4);
    chk("rerun_start_frst", 32'(frst_cnt - fr0), 32'd1);
    repeat (3) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", all_outs(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_symbol_packer.md
MAC_SYMBOL_PACKER -- requirements
Module: mac_symbol_packer

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, 4, symbol FIFO entries (power of 2, at least 4).
- SYM_W, 4, maximum bits per symbol.
- FRAME_W, 10, width of the symbols-per-frame count.

REQ-002 The block SHALL have these ports:
- SERIAL_CLK  in  1  sole clock, rising edge.
- MAC_RST_N  in  1  reset, synchronous, active-low.
- START  in  1  frame start request.
- BITS_PER_SYM  in  3  bits per symbol, legal range 1..SYM_W.
- SYMS_PER_FRAME  in  FRAME_W  symbols per frame.
- FRAME_RST  out  1  one-cycle reset pulse to the upstream PRBS PHY_RST input.
- READ_ENABLE  out  1  bit request to the upstream PRBS.
- BIT_IN  in  1  serial bit from upstream DATA_OUTPUT.
- BIT_IN_VALID  in  1  upstream DATA_OUTPUT_VALID.
- SYM_OUT  out  SYM_W  packed symbol.
- SYM_VALID  out  1  SYM_OUT is valid.
- SYM_READY  in  1  downstream accepts the symbol.
- SYM_LAST  out  1  marks the final symbol of the frame.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_DONE  out  1  one-cycle frame completion pulse.

Function
REQ-003 The block SHALL implement the FSM IDLE -> PRIME -> RUN -> DRAIN -> IDLE.
REQ-004 In IDLE, START=1 with SYMS_PER_FRAME!=0 and BITS_PER_SYM in 1..SYM_W SHALL latch both values and move to PRIME; any other START SHALL be ignored, and START SHALL be ignored outside IDLE.
REQ-005 PRIME SHALL last exactly one cycle, drive FRAME_RST=1 registered in that cycle, hold READ_ENABLE=0, then move to RUN.
REQ-006 The total frame bit count SHALL be SYMS_PER_FRAME*BITS_PER_SYM, computed at full width FRAME_W+3 with no truncation.
REQ-007 READ_ENABLE SHALL be combinational and equal RUN && (bits_requested < total) && (fifo_count + inflight < DEPTH), where inflight is the number of READ_ENABLE assertions in the previous 2 cycles.
REQ-008 The upstream latency SHALL be taken as fixed: each READ_ENABLE high at cycle t returns one BIT_IN_VALID at t+2.
REQ-009 RUN SHALL move to DRAIN in the cycle after bits_requested reaches total.
REQ-010 Bits SHALL be packed LSB-first: the first bit lands in SYM_OUT[0], and SYM_OUT bits at index BITS_PER_SYM and above SHALL be 0.
REQ-011 When BITS_PER_SYM bits have accumulated, the symbol SHALL be pushed to the FIFO in the cycle its last bit arrives, tagged with last=1 if it is symbol number SYMS_PER_FRAME.
REQ-012 BIT_IN_VALID SHALL be ignored in IDLE and PRIME, and ignored once all frame bits have been received.
REQ-013 The FIFO SHALL be first-word fall-through: SYM_VALID = FIFO not empty, SYM_OUT and SYM_LAST show the head entry, and a pop occurs when SYM_VALID && SYM_READY.
REQ-014 A simultaneous push and pop SHALL leave fifo_count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 The FIFO SHALL never overflow; REQ-007 guarantees this for any BITS_PER_SYM.
REQ-016 SYM_OUT and SYM_LAST SHALL hold stable while SYM_VALID=1 and SYM_READY=0.
REQ-017 Popping the last-tagged symbol SHALL return the FSM to IDLE and pulse FRAME_DONE=1 in the following cycle.
REQ-018 BUSY SHALL be 1 in PRIME, RUN and DRAIN.

Reset
REQ-019 MAC_RST_N=0 sampled at a clock edge SHALL return the FSM to IDLE and clear the FIFO, pointers, counters, inflight history and the bit accumulator.
REQ-020 During and after reset, all outputs SHALL be 0 (FRAME_RST, READ_ENABLE, SYM_OUT, SYM_VALID, SYM_LAST, BUSY, FRAME_DONE) until the next valid START.
REQ-021 A reset mid-frame SHALL discard the partial symbol and all queued symbols; bits arriving after reset release SHALL be ignored (the FSM is in IDLE).

Configuration
REQ-022 With MAC_PACKER_GRAY_EN defined, each packed value SHALL be Gray-mapped (v XOR (v>>1)) before the FIFO push.
REQ-023 Without MAC_PACKER_GRAY_EN, the raw packed value SHALL be pushed; all timing SHALL be identical in both builds.

Verification
REQ-024 START with BPS=2 and SPF=3, SYM_READY=1 -> FRAME_RST pulses 1 cycle; 6 READ_ENABLE cycles; 3 symbols out; SYM_LAST on the 3rd; FRAME_DONE 1 cycle after it.
REQ-025 Bits 1,0,1,1 with BPS=4, no Gray -> SYM_OUT=4'hD; with MAC_PACKER_GRAY_EN -> SYM_OUT=4'hB.
REQ-026 BPS=1, SPF=16, SYM_READY=0 -> fifo_count stops at 4 with no overflow and READ_ENABLE low; releasing SYM_READY -> all 16 symbols delivered in order.
REQ-027 START with SPF=0, BPS=0 or BPS=5 -> ignored; BUSY stays 0; no FRAME_RST.
REQ-028 MAC_RST_N=0 mid-RUN after 2 symbols -> all outputs 0 next cycle; a new START produces a fresh frame identical to an unreset run.
REQ-029 START pulsed during RUN -> no effect on the frame; symbol count unchanged.
